// File: rtl/pc_pkg.sv
// Shared classifier definitions: field widths, command encodings and the
// aligned result record handed downstream.
package pc_pkg;

    localparam int INDEX_BIT_LEN   = 11;
    localparam int COMMAND_BIT_LEN = 2;
    localparam int TAG_BIT_LEN     = 8;

    localparam logic [COMMAND_BIT_LEN-1:0] CMD_SEARCH = 2'b01;
    localparam logic [COMMAND_BIT_LEN-1:0] CMD_UPDATE = 2'b10;

    typedef struct packed {
        logic [TAG_BIT_LEN-1:0]   tag;
        logic                     match;
        logic [INDEX_BIT_LEN-1:0] matchID;
    } cls_result_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/match_result_collector_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is read straight out of
// the storage flops so the outputs are stable while the consumer stalls.
module result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage is cleared on reset so the idle head reads as all zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/match_result_collector.sv
// Aligns issued search tags with the classifier's registered result, buffers
// {tag, match, matchID} and returns issue credits as results are consumed.
module match_result_collector
    import pc_pkg::CMD_SEARCH;
    import pc_pkg::sat_inc;
#(
    parameter int INDEX_BIT_LEN   = pc_pkg::INDEX_BIT_LEN,
    parameter int COMMAND_BIT_LEN = pc_pkg::COMMAND_BIT_LEN,
    parameter int TAG_BIT_LEN     = pc_pkg::TAG_BIT_LEN,
    parameter int PIPE_LAT        = 4,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [COMMAND_BIT_LEN-1:0] issue_cmd,
    input  logic [TAG_BIT_LEN-1:0]     issue_tag,
    output logic                       issue_ready,
    input  logic                       cls_match,
    input  logic [INDEX_BIT_LEN-1:0]   cls_matchID,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_BIT_LEN-1:0]     res_tag,
    output logic                       res_match,
    output logic [INDEX_BIT_LEN-1:0]   res_matchID,
    output logic [15:0]                search_cnt,
    output logic [15:0]                hit_cnt
);

    localparam int RES_W = TAG_BIT_LEN + 1 + INDEX_BIT_LEN;
    localparam int OUT_W = $clog2(FIFO_DEPTH) + 1;

    logic                     accept, pop, push;
    logic [PIPE_LAT-1:0]      pipe_vld_q, pipe_vld_d;
    logic [TAG_BIT_LEN-1:0]   pipe_tag_q [PIPE_LAT];
    logic [TAG_BIT_LEN-1:0]   pipe_tag_d [PIPE_LAT];
    logic [OUT_W-1:0]         outstanding_q, outstanding_d;
    logic [15:0]              search_cnt_q, search_cnt_d;
    logic [15:0]              hit_cnt_q, hit_cnt_d;
    logic [INDEX_BIT_LEN-1:0] masked_id;
    logic [RES_W-1:0]         push_data, head_data;
    logic                     fifo_full, fifo_empty;

    assign issue_ready = (outstanding_q < OUT_W'(FIFO_DEPTH));
    assign accept      = issue_valid && issue_ready &&
                         (issue_cmd == COMMAND_BIT_LEN'(CMD_SEARCH));
    assign res_valid   = !fifo_empty;
    assign pop         = res_valid && res_ready;
    assign push        = pipe_vld_q[PIPE_LAT-1];
    assign masked_id   = cls_match ? cls_matchID : '0;
    assign push_data   = {pipe_tag_q[PIPE_LAT-1], cls_match, masked_id};

    assign {res_tag, res_match, res_matchID} = head_data;
    assign search_cnt = search_cnt_q;
    assign hit_cnt    = hit_cnt_q;

    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = accept;
        pipe_tag_d[0] = issue_tag;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end

        // Credits cover both in-flight and buffered results.
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        search_cnt_d = accept ? sat_inc(search_cnt_q) : search_cnt_q;
        hit_cnt_d    = (push && cls_match) ? sat_inc(hit_cnt_q) : hit_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pipe_tag_q[i] <= '0;
            outstanding_q <= '0;
            search_cnt_q  <= '0;
            hit_cnt_q     <= '0;
        end else begin
            pipe_vld_q    <= pipe_vld_d;
            pipe_tag_q    <= pipe_tag_d;
            outstanding_q <= outstanding_d;
            search_cnt_q  <= search_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_match_result_collector.sv
// Directed and randomized checks of match_result_collector against a
// queue-based model of issued searches and delivered results.
module tb_match_result_collector;
    import pc_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_cmd = 2'b00;
    logic [7:0]  issue_tag = 8'h00;
    logic        issue_ready;
    logic        cls_match = 1'b0;
    logic [10:0] cls_matchID = 11'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_tag;
    logic        res_match;
    logic [10:0] res_matchID;
    logic [15:0] search_cnt, hit_cnt;

    always #5 clk = ~clk;

    match_result_collector #(
        .INDEX_BIT_LEN   (11),
        .COMMAND_BIT_LEN (2),
        .TAG_BIT_LEN     (8),
        .PIPE_LAT        (LAT),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_cmd   (issue_cmd),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .cls_match   (cls_match),
        .cls_matchID (cls_matchID),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_tag     (res_tag),
        .res_match   (res_match),
        .res_matchID (res_matchID),
        .search_cnt  (search_cnt),
        .hit_cnt     (hit_cnt)
    );

    typedef struct {
        logic [7:0] tag;
        int         due;
    } fl_t;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    fl_t          inflight[$];
    cls_result_t  outq[$];
    logic [15:0]  m_scnt = 16'd0;
    logic [15:0]  m_hcnt = 16'd0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return (outq.size() + inflight.size()) < DEPTH;
    endfunction

    task automatic check_model();
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, m_ready()});
        chk("res_valid", {31'd0, res_valid}, {31'd0, outq.size() != 0});
        if (outq.size() != 0) begin
            chk("res_tag", {24'd0, res_tag}, {24'd0, outq[0].tag});
            chk("res_match", {31'd0, res_match}, {31'd0, outq[0].match});
            chk("res_matchID", {21'd0, res_matchID}, {21'd0, outq[0].matchID});
        end
        chk("search_cnt", {16'd0, search_cnt}, {16'd0, m_scnt});
        chk("hit_cnt", {16'd0, hit_cnt}, {16'd0, m_hcnt});
    endtask

    // One clock cycle: check, drive, advance the model at the edge.
    task automatic step(input logic iv, input logic [1:0] cmd, input logic [7:0] tag,
                        input logic rr, input logic cm, input logic [10:0] cid);
        logic        due, acc, pp;
        fl_t         f;
        cls_result_t r;
        check_model();
        issue_valid = iv;
        issue_cmd   = cmd;
        issue_tag   = tag;
        res_ready   = rr;
        due = (inflight.size() != 0) && (inflight[0].due == cyc);
        cls_match   = due ? cm  : 1'($urandom);
        cls_matchID = due ? cid : 11'($urandom);
        acc = iv && (cmd == CMD_SEARCH) && m_ready();
        pp  = rr && (outq.size() != 0);
        @(posedge clk);
        if (pp) void'(outq.pop_front());
        if (due) begin
            f = inflight.pop_front();
            r.tag     = f.tag;
            r.match   = cm;
            r.matchID = cm ? cid : 11'd0;
            outq.push_back(r);
            if (cm && m_hcnt != 16'hFFFF) m_hcnt++;
        end
        if (acc) begin
            f.tag = tag;
            f.due = cyc + LAT;
            inflight.push_back(f);
            if (m_scnt != 16'hFFFF) m_scnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 2'b00, 8'h00, rr, 1'($urandom), 11'($urandom));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_cmd   = 2'b00;
        res_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        inflight.delete();
        outq.delete();
        m_scnt = 16'd0;
        m_hcnt = 16'd0;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_issue_ready"}, {31'd0, issue_ready}, 32'd1);
        chk({pfx, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({pfx, "_res_tag"}, {24'd0, res_tag}, 32'd0);
        chk({pfx, "_res_match"}, {31'd0, res_match}, 32'd0);
        chk({pfx, "_res_matchID"}, {21'd0, res_matchID}, 32'd0);
        chk({pfx, "_search_cnt"}, {16'd0, search_cnt}, 32'd0);
        chk({pfx, "_hit_cnt"}, {16'd0, hit_cnt}, 32'd0);
    endtask

    initial begin
        int exp_s;
        logic [1:0] c;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset("reset");

        // single search, hit
        step(1'b1, CMD_SEARCH, 8'h2A, 1'b1, 1'b1, 11'd517);
        repeat (LAT) step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 11'd517);
        chk("single_valid", {31'd0, res_valid}, 32'd1);
        chk("single_tag", {24'd0, res_tag}, 32'h2A);
        chk("single_match", {31'd0, res_match}, 32'd1);
        chk("single_id", {21'd0, res_matchID}, 32'd517);
        chk("single_scnt", {16'd0, search_cnt}, 32'd1);
        chk("single_hcnt", {16'd0, hit_cnt}, 32'd1);
        idle(1'b1);

        // miss masks the classifier's ID
        step(1'b1, CMD_SEARCH, 8'h03, 1'b1, 1'b0, 11'd99);
        repeat (LAT) step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 11'd99);
        chk("miss_valid", {31'd0, res_valid}, 32'd1);
        chk("miss_tag", {24'd0, res_tag}, 32'h03);
        chk("miss_match", {31'd0, res_match}, 32'd0);
        chk("miss_id", {21'd0, res_matchID}, 32'd0);
        chk("miss_hcnt", {16'd0, hit_cnt}, 32'd1);
        idle(1'b1);

        // fill all credits with the consumer stalled
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, CMD_SEARCH, 8'(i), 1'b0, 1'($urandom), 11'($urandom));
        chk("full_ready", {31'd0, issue_ready}, 32'd0);
        step(1'b1, CMD_SEARCH, 8'd16, 1'b0, 1'($urandom), 11'($urandom));
        chk("full_17th_scnt", {16'd0, search_cnt}, 32'd18);
        repeat (LAT + 1) idle(1'b0);
        chk("full_head_tag", {24'd0, res_tag}, 32'd0);
        chk("full_still_blocked", {31'd0, issue_ready}, 32'd0);
        idle(1'b1);
        chk("credit_return", {31'd0, issue_ready}, 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("order_tag", {24'd0, res_tag}, 32'(i));
            idle(1'b1);
        end
        chk("full_drained", {31'd0, res_valid}, 32'd0);

        // updates and illegal commands produce nothing
        exp_s = 18;
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom);
            if (c == CMD_SEARCH) exp_s++;
            step(1'b1, c, 8'($urandom), 1'b1, 1'($urandom), 11'($urandom));
        end
        repeat (LAT + 2) idle(1'b1);
        chk("mix_scnt", {16'd0, search_cnt}, 32'(exp_s));
        chk("mix_empty", {31'd0, res_valid}, 32'd0);
        chk("mix_ready", {31'd0, issue_ready}, 32'd1);

        // streaming: one result per cycle once the pipe is full
        for (int i = 0; i < 100; i++) begin
            if (i > LAT) chk("stream_valid", {31'd0, res_valid}, 32'd1);
            chk("stream_ready", {31'd0, issue_ready}, 32'd1);
            step(1'b1, CMD_SEARCH, 8'(i), 1'b1, 1'($urandom), 11'($urandom));
        end
        repeat (LAT + 2) idle(1'b1);

        // fully random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 2'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), 11'($urandom));
        repeat (DEPTH + LAT + 4) idle(1'b1);

        // reset with three in flight and five buffered
        for (int i = 0; i < 8; i++)
            step(1'b1, CMD_SEARCH, 8'(8'h80 + i), 1'b0, 1'b1, 11'($urandom));
        idle(1'b0);
        chk("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        chk("pre_rst_tag", {24'd0, res_tag}, 32'h80);
        do_reset();
        check_reset("midrst");
        repeat (LAT + 4) step(1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 11'($urandom));
        chk("post_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("post_rst_hcnt", {16'd0, hit_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
